// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared types and default sizes for the instruction-fetch block.
//   - ADDR_W / INSTR_W / DEPTH : default PC width, instruction width and
//     output-buffer depth.
//   - fetch_state_t : fetch controller states.
//   - fetch_entry_t : one buffered {pc, instr} pair handed to decode.
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int ADDR_W  = 9;
  localparam int INSTR_W = 9;
  localparam int DEPTH   = 2;

  typedef enum logic [1:0] {
    BOOT = 2'd0,  // single idle cycle after reset release
    RUN  = 2'd1,  // normal issue
    HALT = 2'd2   // program done; only a flush restarts fetch
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
//   Bundles every non-clock signal of the fetch unit: PC interface, control
//   (flush/halt), instruction-memory read port and the decode handshake.
//   master : the fetch unit itself (drives pc_hold, imem_*, dec_* outputs)
//   slave  : the surroundings (PC, instruction memory, decode)
// ---------------------------------------------------------------------------
interface instr_fetch_if #(
  parameter int ADDR_W  = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) ();

  logic [ADDR_W-1:0]  pc_addr;     // current PC value
  logic               pc_hold;     // 1 = PC must not advance this cycle
  logic               flush;       // taken jump; PC loads target this edge
  logic               halt;        // stop issuing new fetches
  logic               imem_req;    // read strobe
  logic [ADDR_W-1:0]  imem_addr;   // read address
  logic [INSTR_W-1:0] imem_rdata;  // read data, one cycle after imem_req
  logic               dec_valid;   // buffer head valid
  logic               dec_ready;   // decode accepts head
  logic [INSTR_W-1:0] dec_instr;   // head instruction
  logic [ADDR_W-1:0]  dec_pc;      // address the head was fetched from

  modport master (
    input  pc_addr, flush, halt, imem_rdata, dec_ready,
    output pc_hold, imem_req, imem_addr, dec_valid, dec_instr, dec_pc
  );

  modport slave (
    output pc_addr, flush, halt, imem_rdata, dec_ready,
    input  pc_hold, imem_req, imem_addr, dec_valid, dec_instr, dec_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   DEPTH-entry FIFO of {pc, instr} pairs between the memory response and
//   decode. Push and pop in the same cycle are both honoured; clear wins
//   over both. Pointers wrap naturally because DEPTH is a power of two.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     i_push       : write i_entry at the tail
//     i_pop        : drop the head
//     i_clear      : empty the buffer at the next edge
//     i_entry      : entry to push
//     o_count      : number of valid entries (0..DEPTH)
//     o_head       : entry at the head (meaningful when o_count != 0)
// ---------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = fetch_pkg::DEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  entry_t           i_entry,
  output logic [CNT_W-1:0] o_count,
  output entry_t           o_head
);

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: storage is reset too, so the head outputs read zero out of
      // reset instead of X; keep this only while the buffer stays tiny.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // The issue logic reserves a slot before every fetch, so these never fire.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
    !(i_push && !i_pop && !i_clear && (r_count == CNT_W'(DEPTH))));
  a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n)
    !(i_pop && !i_clear && (r_count == '0)));

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Consumer side of the PC interface. Issues reads to a 1-cycle-latency
//   instruction memory, buffers returned {pc, instr} pairs and presents them
//   to decode over valid/ready. pc_hold stops the PC whenever a fetch cannot
//   be issued, so the address stream never outruns buffer space. A flush
//   (taken jump) discards buffered and in-flight fetches.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     bus          : instr_fetch_if.master (PC, flush/halt, imem, decode)
// ---------------------------------------------------------------------------
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter int DEPTH   = fetch_pkg::DEPTH
) (
  input logic           clk,
  input logic           reset_n,
  instr_fetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic               r_inflight;   // a read was issued last cycle
  logic [ADDR_W-1:0]  r_pc_q;       // address of that read
  logic               w_issue;
  logic               w_pop;
  logic               w_push;
  logic [CNT_W-1:0]   w_count;
  logic [OCC_W-1:0]   w_occ;
  entry_t             w_push_entry;
  entry_t             w_head;

  assign w_pop = bus.dec_valid & bus.dec_ready;

  // Slots that will be occupied after this edge if nothing new is issued:
  // buffered + the response landing now - the entry decode takes now.
  assign w_occ = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);

  assign w_issue = (r_state == RUN) && !bus.halt && !bus.flush &&
                   (w_occ < OCC_W'(DEPTH));

  // A flush in the cycle the response arrives cancels it: the FIFO is being
  // cleared on the same edge and the push is suppressed.
  assign w_push       = r_inflight & ~bus.flush;
  assign w_push_entry = '{pc: r_pc_q, instr: bus.imem_rdata};

  // Flush beats halt: a jump always restarts fetch at the target.
  always_comb begin
    // NOTE: default assigned first so no branch leaves the signal
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     if (!bus.flush && bus.halt) w_state_nxt = HALT;
      HALT:    if (bus.flush) w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= BOOT;
      r_inflight <= 1'b0;
      r_pc_q     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_issue) r_pc_q <= bus.pc_addr;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (bus.flush),
    .i_entry (w_push_entry),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign bus.imem_req  = w_issue;
  assign bus.pc_hold   = ~w_issue;
  assign bus.imem_addr = bus.pc_addr;
  assign bus.dec_valid = (w_count != '0);
  assign bus.dec_instr = w_head.instr;
  assign bus.dec_pc    = w_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Drives instr_fetch through directed scenarios and a random run. The
//   reference model tracks the decode buffer and pending memory reads as
//   queues, plus a PC that advances whenever the model expects an issue.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(9), .INSTR_W(9)) bus ();

  instr_fetch #(.ADDR_W(9), .INSTR_W(9), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Instruction memory: synchronous read, garbage when not requested.
  logic [8:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = 9'(i + 'h100);
  always @(posedge clk) bus.imem_rdata <= bus.imem_req ? mem[bus.imem_addr] : 9'($urandom);

  typedef struct {
    logic [8:0] pc;
    logic [8:0] instr;
  } ent_t;

  ent_t       m_buf[$];     // entries visible to decode, oldest first
  logic [8:0] m_pend[$];    // reads whose data returns next edge
  bit         m_booted, m_halted;
  logic [8:0] m_pc;

  bit         c_flush, c_halt;
  logic [8:0] c_target;
  bit         e_issue, e_valid, e_pop;

  int checks   = 0;
  int failures = 0;

  function automatic logic [29:0] exp_vec();
    ent_t h = '{pc: 9'd0, instr: 9'd0};
    if (e_valid) h = m_buf[0];
    return {e_issue, ~e_issue, m_pc, e_valid, h.pc, h.instr};
  endfunction

  function automatic logic [29:0] obs_vec();
    return {bus.imem_req, bus.pc_hold, bus.imem_addr, bus.dec_valid,
            bus.dec_valid ? bus.dec_pc : 9'd0, bus.dec_valid ? bus.dec_instr : 9'd0};
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_pend.delete();
    m_booted = 0;
    m_halted = 0;
    m_pc     = '0;
  endtask

  // Called at a falling edge: apply inputs and work out expectations.
  task automatic drive(input bit fl, input bit ha, input bit rd, input logic [8:0] tgt);
    c_flush = fl; c_halt = ha; c_target = tgt;
    bus.flush = fl; bus.halt = ha; bus.dec_ready = rd; bus.pc_addr = m_pc;
    e_valid = (m_buf.size() != 0);
    e_pop   = e_valid && rd;
    e_issue = m_booted && !m_halted && !ha && !fl &&
              (m_buf.size() + m_pend.size() - (e_pop ? 1 : 0) < DEPTH);
    #1;
  endtask

  // Cross the rising edge, update the model, return at the next falling edge.
  task automatic advance();
    @(posedge clk);
    if (c_flush) begin
      m_buf.delete();
      m_pend.delete();
    end else begin
      if (e_pop) void'(m_buf.pop_front());
      if (m_pend.size() != 0) begin
        m_buf.push_back('{pc: m_pend[0], instr: mem[m_pend[0]]});
        m_pend.delete();
      end
    end
    if (e_issue) m_pend.push_back(m_pc);
    if (!m_booted)    m_booted = 1;
    else if (c_flush) m_halted = 0;
    else if (c_halt)  m_halted = 1;
    if (c_flush)      m_pc = c_target;
    else if (e_issue) m_pc = m_pc + 9'd1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.flush = 0; bus.halt = 0; bus.dec_ready = 0; bus.pc_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.dec_valid, bus.dec_instr, bus.dec_pc, bus.imem_req, bus.pc_hold} !== {1'b0, 9'd0, 9'd0, 1'b0, 1'b1})
      begin failures++; $display("FAIL reset_state: got v=%b i=%h pc=%h req=%b hold=%b expected 0/000/000/0/1",
        bus.dec_valid, bus.dec_instr, bus.dec_pc, bus.imem_req, bus.pc_hold); end
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 9'd0);
      checks++;
      if (obs_vec() !== exp_vec()) begin failures++;
        $display("FAIL stream cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
      if (i >= 3) begin
        checks++;
        if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 9'(i - 3), 9'(i - 3 + 'h100)}) begin failures++;
          $display("FAIL stream_seq cyc%0d: got v=%b pc=%h i=%h expected pc=%h", i,
            bus.dec_valid, bus.dec_pc, bus.dec_instr, 9'(i - 3)); end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 9'd0);
      checks++;
      if (obs_vec() !== exp_vec()) begin failures++;
        $display("FAIL stall cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
      advance();
    end
    drive(0, 0, 0, 9'd0);
    checks++;
    if ({bus.pc_hold, bus.dec_valid, bus.imem_req} !== 3'b110) begin failures++;
      $display("FAIL stall_full: got hold=%b v=%b req=%b expected 1/1/0", bus.pc_hold, bus.dec_valid, bus.imem_req); end
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 9'd0);
      checks++;
      if (obs_vec() !== exp_vec()) begin failures++;
        $display("FAIL release cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
      advance();
    end
  endtask

  task automatic test_flush();
    bit seen = 0;
    logic [17:0] first = '0;
    drive(1, 0, 1, 9'h040);
    checks++;
    if (obs_vec() !== exp_vec()) begin failures++;
      $display("FAIL flush_cycle: got %h expected %h", obs_vec(), exp_vec()); end
    advance();
    drive(0, 0, 1, 9'd0);
    checks++;
    if ({bus.dec_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 9'h040}) begin failures++;
      $display("FAIL flush_next: got v=%b req=%b addr=%h expected 0/1/040", bus.dec_valid, bus.imem_req, bus.imem_addr); end
    advance();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 1, 9'd0);
      checks++;
      if (obs_vec() !== exp_vec()) begin failures++;
        $display("FAIL flush_after cyc%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
      if (!seen && bus.dec_valid === 1'b1) begin seen = 1; first = {bus.dec_pc, bus.dec_instr}; end
      advance();
    end
    checks++;
    if (!seen || first !== {9'h040, 9'h140}) begin failures++;
      $display("FAIL flush_first_valid: got seen=%b pc/instr=%h expected 040/140", seen, first); end
  endtask

  task automatic test_halt();
    drive(1, 0, 1, 9'h003);
    advance();
    for (int k = 0; k < 10 && m_pc != 9'd5; k++) begin
      drive(0, 0, 1, 9'd0);
      checks++;
      if (obs_vec() !== exp_vec()) begin failures++;
        $display("FAIL pre_halt cyc%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
      advance();
    end
    drive(0, 1, 0, 9'd0);
    checks++;
    if (obs_vec() !== exp_vec()) begin failures++;
      $display("FAIL halt_cycle: got %h expected %h", obs_vec(), exp_vec()); end
    advance();
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, k >= 2, 9'd0);
      checks++;
      if (obs_vec() !== exp_vec() || bus.imem_req !== 1'b0) begin failures++;
        $display("FAIL halt_drain cyc%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
      advance();
    end
    drive(0, 0, 1, 9'd0);
    checks++;
    if ({bus.dec_valid, bus.imem_req} !== 2'b00) begin failures++;
      $display("FAIL halt_idle: got v=%b req=%b expected 0/0", bus.dec_valid, bus.imem_req); end
    advance();
    drive(1, 0, 1, 9'h010);
    advance();
    drive(0, 0, 1, 9'd0);
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 9'h010}) begin failures++;
      $display("FAIL halt_restart: got req=%b addr=%h expected 1/010", bus.imem_req, bus.imem_addr); end
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 9'd0);
      checks++;
      if (obs_vec() !== exp_vec()) begin failures++;
        $display("FAIL restart cyc%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
      advance();
    end
  endtask

  task automatic test_flush_halt();
    drive(1, 1, 1, 9'h0A0);
    advance();
    drive(0, 0, 1, 9'd0);
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 9'h0A0}) begin failures++;
      $display("FAIL flush_halt: got req=%b addr=%h expected 1/0a0", bus.imem_req, bus.imem_addr); end
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 9'd0);
      checks++;
      if (obs_vec() !== exp_vec()) begin failures++;
        $display("FAIL flush_halt_after cyc%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
      advance();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 3) != 0, 9'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin failures++;
        $display("FAIL random cyc%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
      advance();
    end
  endtask

  task automatic test_reset_midstream();
    drive(1, 0, 1, 9'h020);
    advance();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 9'd0);
      checks++;
      if (obs_vec() !== exp_vec()) begin failures++;
        $display("FAIL pre_reset cyc%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
      if (e_valid) break;
      advance();
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.dec_valid, bus.dec_instr, bus.dec_pc, bus.imem_req, bus.pc_hold} !== {1'b0, 9'd0, 9'd0, 1'b0, 1'b1})
      begin failures++; $display("FAIL async_reset: got v=%b i=%h pc=%h req=%b hold=%b expected 0/000/000/0/1",
        bus.dec_valid, bus.dec_instr, bus.dec_pc, bus.imem_req, bus.pc_hold); end
    model_reset();
    bus.flush = 0; bus.halt = 0; bus.dec_ready = 0; bus.pc_addr = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 9'd0);
      checks++;
      if (obs_vec() !== exp_vec()) begin failures++;
        $display("FAIL post_reset cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
      if (i == 3) begin
        checks++;
        if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 9'h000, 9'h100}) begin failures++;
          $display("FAIL post_reset_first: got v=%b pc=%h i=%h expected 1/000/100",
            bus.dec_valid, bus.dec_pc, bus.dec_instr); end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_halt();
    test_flush_halt();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
